// File: rtl/riscv_retire_monitor.sv
// ---------------------------------------------------------------------------
// riscv_retire_monitor
//
// Retirement-side observability block of the RISC-V core. Fed by the
// commit/writeback stage, it counts retired instructions, keeps the result
// value of the most recent retirement and detects the two-instruction
// program-end sequence (HALT_INST0 followed by HALT_INST1).
//
// Optional feature macro: STALL_WATCHDOG_EN
//   When defined, a stall watchdog raises ERR and HALT after WDOG_LIMIT
//   consecutive cycles with no accepted retirement. When undefined, ERR is
//   tied low and HALT comes only from the halt sequence.
//
// Parameters
//   DWIDTH      data width of result / store address / OUTPUT_PORT
//   CNT_WIDTH   width of the NUM_INST counter (wraps at 2^CNT_WIDTH)
//   HALT_INST0  first word of the halt sequence
//   HALT_INST1  second word of the halt sequence
//   WDOG_LIMIT  idle cycles before the watchdog trips (watchdog builds only)
//
// Ports
//   CLK            in   clock, all state on posedge
//   RSTn           in   synchronous active-low reset
//   RET_VALID      in   one instruction retires this cycle
//   RET_INST       in   encoding of the retiring instruction
//   RET_RD_WE      in   retiring instruction writes a register
//   RET_RD_DATA    in   register write data
//   RET_IS_STORE   in   retiring instruction is a store
//   RET_ST_ADDR    in   store effective address
//   RET_IS_BRANCH  in   retiring instruction is a conditional branch
//   RET_BR_TAKEN   in   branch outcome
//   NUM_INST       out  retired-instruction count
//   OUTPUT_PORT    out  result of the most recent retirement
//   HALT           out  program finished (sticky until reset)
//   ERR            out  watchdog trip flag (sticky until reset)
// ---------------------------------------------------------------------------
module riscv_retire_monitor #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [31:0] HALT_INST0 = 32'h00c00093,
  parameter logic [31:0] HALT_INST1 = 32'h00008067,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RET_VALID,
  input  logic [31:0]          RET_INST,
  input  logic                 RET_RD_WE,
  input  logic [DWIDTH-1:0]    RET_RD_DATA,
  input  logic                 RET_IS_STORE,
  input  logic [DWIDTH-1:0]    RET_ST_ADDR,
  input  logic                 RET_IS_BRANCH,
  input  logic                 RET_BR_TAKEN,
  output logic [CNT_WIDTH-1:0] NUM_INST,
  output logic [DWIDTH-1:0]    OUTPUT_PORT,
  output logic                 HALT,
  output logic                 ERR
);

  // The watchdog needs at least one idle cycle before its terminal count.
  if (WDOG_LIMIT < 2) begin : g_cfg_chk
    $error("riscv_retire_monitor: WDOG_LIMIT must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_num_inst;
  logic [DWIDTH-1:0]      r_out;
  logic                   r_halt;
  logic                   w_accept;
  logic                   w_seq_done;
  logic                   w_wdog_trip;

  // A retirement only counts while the program is still running.
  assign w_accept = RET_VALID & ~r_halt;

  // ---- stall watchdog ------------------------------------------------------
`ifdef STALL_WATCHDOG_EN
  localparam int unsigned WDOG_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;

  // r_wdog holds the number of idle cycles already seen; the idle cycle that
  // finds it at WDOG_LAST is the WDOG_LIMIT-th one and trips the watchdog.
  assign w_wdog_trip = ~r_halt & ~RET_VALID & (r_wdog == WDOG_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wdog <= '0;
      end else if (!r_halt && !w_wdog_trip) begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end
      if (w_wdog_trip) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ERR = r_err;
`else
  assign w_wdog_trip = 1'b0;
  assign ERR         = 1'b0;
`endif

  // ---- halt-sequence FSM ---------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ARMED means "the last accepted instruction was HALT_INST0"; a repeated
  // HALT_INST0 therefore keeps the sequence armed.
  always_comb begin
    w_state_nxt = r_state;
    w_seq_done  = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (RET_INST == HALT_INST0) begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (RET_INST == HALT_INST1) begin
            w_state_nxt = ST_DONE;
            w_seq_done  = 1'b1;
          end else if (RET_INST == HALT_INST0) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    // A watchdog trip ends the program just like the halt sequence.
    if (w_wdog_trip) begin
      w_state_nxt = ST_DONE;
    end
  end

  // ---- retirement counters and result register -----------------------------
  // The halting instruction itself is counted and updates the result in the
  // same edge that raises HALT.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_num_inst <= '0;
      r_out      <= '0;
      r_halt     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num_inst <= r_num_inst + CNT_WIDTH'(1);
        if (RET_IS_STORE) begin
          r_out <= RET_ST_ADDR;
        end else if (RET_IS_BRANCH) begin
          r_out <= {{(DWIDTH-1){1'b0}}, RET_BR_TAKEN};
        end else if (RET_RD_WE) begin
          r_out <= RET_RD_DATA;
        end
      end
      if (w_seq_done || w_wdog_trip) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign NUM_INST    = r_num_inst;
  assign OUTPUT_PORT = r_out;
  assign HALT        = r_halt;

  // ---- invariants -----------------------------------------------------------
  // Once halted, nothing but reset may change the observable state.
  a_halt_sticky: assert property (@(posedge CLK) (RSTn && r_halt) |=> r_halt);
  a_cnt_frozen:  assert property (@(posedge CLK) (RSTn && r_halt) |=> $stable(r_num_inst));
  a_out_frozen:  assert property (@(posedge CLK) (RSTn && r_halt) |=> $stable(r_out));
  // HALT and the terminal FSM state are always raised and cleared together.
  a_done_halt:   assert property (@(posedge CLK) RSTn |-> ((r_state == ST_DONE) == r_halt));

endmodule

// File: tb/tb_riscv_retire_monitor.sv
module tb_riscv_retire_monitor;

  localparam int          DW   = 32;
  localparam int          CW   = 8;
  localparam int          WL   = 8;
  localparam logic [31:0] H0   = 32'h00c00093;
  localparam logic [31:0] H1   = 32'h00008067;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SW   = 32'h1020a023;
  localparam logic [31:0] BEQ  = 32'h00208463;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          RET_VALID;
  logic [31:0]   RET_INST;
  logic          RET_RD_WE;
  logic [DW-1:0] RET_RD_DATA;
  logic          RET_IS_STORE;
  logic [DW-1:0] RET_ST_ADDR;
  logic          RET_IS_BRANCH;
  logic          RET_BR_TAKEN;
  logic [CW-1:0] NUM_INST;
  logic [DW-1:0] OUTPUT_PORT;
  logic          HALT;
  logic          ERR;

  riscv_retire_monitor #(
    .DWIDTH(DW), .CNT_WIDTH(CW), .HALT_INST0(H0), .HALT_INST1(H1), .WDOG_LIMIT(WL)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .RET_VALID(RET_VALID), .RET_INST(RET_INST),
    .RET_RD_WE(RET_RD_WE), .RET_RD_DATA(RET_RD_DATA), .RET_IS_STORE(RET_IS_STORE),
    .RET_ST_ADDR(RET_ST_ADDR), .RET_IS_BRANCH(RET_IS_BRANCH), .RET_BR_TAKEN(RET_BR_TAKEN),
    .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT), .HALT(HALT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rstn;
    bit          valid;
    logic [31:0] inst;
    bit          rdwe;
    logic [31:0] rddata;
    bit          st;
    logic [31:0] staddr;
    bit          br;
    bit          taken;
  } in_t;

  typedef struct {
    in_t         stim;
    int          cnt;
    logic [31:0] out;
    bit          halt;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: state of the program derived from the history of
  // accepted retirements.
  int          m_cnt;
  logic [31:0] m_out;
  bit          m_halt;
  bit          m_err;
  logic [31:0] m_prev;   // last accepted instruction word
  int          m_idle;   // consecutive running cycles without a retirement

  function automatic in_t vin(bit rstn, bit valid, logic [31:0] inst, bit rdwe,
                              logic [31:0] rdd, bit st, logic [31:0] sta, bit br, bit tk);
    in_t r;
    r.rstn = rstn; r.valid = valid; r.inst = inst; r.rdwe = rdwe; r.rddata = rdd;
    r.st = st; r.staddr = sta; r.br = br; r.taken = tk;
    return r;
  endfunction

  function automatic in_t rst_in();
    return vin(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic in_t idle_in();
    return vin(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic in_t rd_in(logic [31:0] inst, logic [31:0] d);
    return vin(1'b1, 1'b1, inst, 1'b1, d, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic in_t plain_in(logic [31:0] inst);
    return vin(1'b1, 1'b1, inst, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  function automatic void model_step(in_t v);
    if (!v.rstn) begin
      m_cnt = 0; m_out = '0; m_halt = 1'b0; m_err = 1'b0; m_prev = '0; m_idle = 0;
    end else if (!m_halt) begin
      if (v.valid) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (v.st)        m_out = v.staddr;
        else if (v.br)   m_out = {31'b0, v.taken};
        else if (v.rdwe) m_out = v.rddata;
        if (m_prev == H0 && v.inst == H1) m_halt = 1'b1;
        m_prev = v.inst;
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
`ifdef STALL_WATCHDOG_EN
        if (m_idle == WL) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
        end
`endif
      end
    end
  endfunction

  task automatic apply(in_t v);
    RSTn = v.rstn; RET_VALID = v.valid; RET_INST = v.inst; RET_RD_WE = v.rdwe;
    RET_RD_DATA = v.rddata; RET_IS_STORE = v.st; RET_ST_ADDR = v.staddr;
    RET_IS_BRANCH = v.br; RET_BR_TAKEN = v.taken;
    @(posedge CLK);
    model_step(v);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, int cnt, logic [31:0] out, bit halt, bit err);
    chk({tag, ".num_inst"}, 32'(NUM_INST), 32'(cnt));
    chk({tag, ".output_port"}, OUTPUT_PORT, out);
    chk({tag, ".halt"}, 32'(HALT), 32'(halt));
    chk({tag, ".err"}, 32'(ERR), 32'(err));
  endtask

  task automatic row(in_t s, int cnt, logic [31:0] out, bit halt);
    vec_t r;
    r.stim = s; r.cnt = cnt; r.out = out; r.halt = halt;
    tbl.push_back(r);
  endtask

  function automatic in_t rand_in(int rate);
    in_t r;
    int  sel;
    r.rstn  = ($urandom_range(0, 199) != 0);
    r.valid = ($urandom_range(0, 9) < rate);
    sel = $urandom_range(0, 15);
    if (sel == 0)      r.inst = H0;
    else if (sel == 1) r.inst = H1;
    else if (sel == 2) r.inst = NOP;
    else               r.inst = $urandom;
    r.rdwe   = $urandom_range(0, 1) == 1;
    r.rddata = $urandom;
    r.st     = $urandom_range(0, 3) == 0;
    r.staddr = $urandom;
    r.br     = $urandom_range(0, 3) == 0;
    r.taken  = $urandom_range(0, 1) == 1;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rate;
    // reset, retirement results, priority and halt-sequence vectors
    row(rst_in(), 0, 32'h0, 1'b0);
    row(rst_in(), 0, 32'h0, 1'b0);
    row(vin(1'b0, 1'b1, ADDI, 1'b1, 32'd5, 1'b0, 32'h0, 1'b0, 1'b0), 0, 32'h0, 1'b0);
    row(rd_in(ADDI, 32'd5), 1, 32'd5, 1'b0);
    row(vin(1'b1, 1'b1, SW, 1'b1, 32'd7, 1'b1, 32'h100, 1'b0, 1'b0), 2, 32'h100, 1'b0);
    row(vin(1'b1, 1'b1, BEQ, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1), 3, 32'h1, 1'b0);
    row(plain_in(NOP), 4, 32'h1, 1'b0);
    row(vin(1'b1, 1'b1, BEQ, 1'b1, 32'h55, 1'b0, 32'h0, 1'b1, 1'b0), 5, 32'h0, 1'b0);
    row(vin(1'b1, 1'b0, ADDI, 1'b1, 32'hdeadbeef, 1'b1, 32'h300, 1'b0, 1'b0), 5, 32'h0, 1'b0);
    row(rd_in(H0, 32'd12), 6, 32'd12, 1'b0);
    row(plain_in(NOP), 7, 32'd12, 1'b0);
    row(plain_in(H1), 8, 32'd12, 1'b0);
    row(plain_in(H0), 9, 32'd12, 1'b0);
    row(plain_in(H0), 10, 32'd12, 1'b0);
    row(plain_in(H1), 11, 32'd12, 1'b1);
    row(rst_in(), 0, 32'h0, 1'b0);
    row(rd_in(H0, 32'd12), 1, 32'd12, 1'b0);
    row(idle_in(), 1, 32'd12, 1'b0);
    row(plain_in(H1), 2, 32'd12, 1'b1);
    row(rd_in(ADDI, 32'd99), 2, 32'd12, 1'b1);
    row(vin(1'b1, 1'b1, SW, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 1'b0), 2, 32'd12, 1'b1);
    row(vin(1'b0, 1'b1, ADDI, 1'b1, 32'd8, 1'b0, 32'h0, 1'b0, 1'b0), 0, 32'h0, 1'b0);
    row(rd_in(ADDI, 32'd5), 1, 32'd5, 1'b0);
    row(vin(1'b1, 1'b1, SW, 1'b1, 32'd3, 1'b1, 32'h44, 1'b1, 1'b1), 2, 32'h44, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].stim);
      chk_out($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].out, tbl[i].halt, 1'b0);
    end

    // watchdog behaviour after a single retirement
    apply(rst_in());
    chk_out("wd_rst", 0, 32'h0, 1'b0, 1'b0);
    apply(rd_in(ADDI, 32'd7));
    chk_out("wd_ret", 1, 32'd7, 1'b0, 1'b0);
`ifdef STALL_WATCHDOG_EN
    for (int k = 1; k < WL; k++) begin
      apply(idle_in());
      chk_out($sformatf("wd_idle%0d", k), 1, 32'd7, 1'b0, 1'b0);
    end
    apply(idle_in());
    chk_out("wd_trip", 1, 32'd7, 1'b1, 1'b1);
    apply(rd_in(ADDI, 32'd9));
    chk_out("wd_frozen", 1, 32'd7, 1'b1, 1'b1);
    apply(rst_in());
    chk_out("wd_clear", 0, 32'h0, 1'b0, 1'b0);
    apply(rd_in(ADDI, 32'd3));
    repeat (WL - 1) apply(idle_in());
    apply(rd_in(ADDI, 32'd4));
    repeat (WL - 1) apply(idle_in());
    chk_out("wd_edge", 2, 32'd4, 1'b0, 1'b0);
    apply(idle_in());
    chk_out("wd_edge_trip", 2, 32'd4, 1'b1, 1'b1);
`else
    for (int k = 1; k <= 5 * WL; k++) begin
      apply(idle_in());
      chk_out($sformatf("wd_off%0d", k), 1, 32'd7, 1'b0, 1'b0);
    end
`endif

    // counter wrap at 2^CNT_WIDTH
    apply(rst_in());
    repeat ((1 << CW) - 1) apply(plain_in(NOP));
    chk_out("wrap_max", (1 << CW) - 1, 32'h0, 1'b0, 1'b0);
    apply(plain_in(NOP));
    chk_out("wrap_zero", 0, 32'h0, 1'b0, 1'b0);
    apply(plain_in(NOP));
    chk_out("wrap_one", 1, 32'h0, 1'b0, 1'b0);

    // randomized traffic against the reference model
    apply(rst_in());
    rate = 7;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) rate = $urandom_range(2, 10);
      apply(rand_in(rate));
      chk_out($sformatf("rnd%0d", c), m_cnt, m_out, m_halt, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
